// File: rtl/lcd_sched_pkg.sv
// Shared types and LCD command constants for the LCD write scheduler.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    POWER_WAIT,
    INIT_ISSUE,
    IDLE,
    ISSUE,
    ACK,
    DRV_WAIT,
    SETTLE
  } state_t;

  localparam logic [7:0] FUNC_SET_4BIT = 8'h28;
  localparam logic [7:0] ENTRY_MODE    = 8'h06;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] HOME          = 8'h02;

  localparam int unsigned INIT_LEN = 4;
  localparam int unsigned IDX_W    = $clog2(INIT_LEN);

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_req_t;

  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET_4BIT;
      2'd1:    return ENTRY_MODE;
      2'd2:    return DISP_ON;
      default: return CLEAR;
    endcase
  endfunction

  // Clear and home are the only commands needing the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CLEAR) || (data == HOME));
  endfunction

endpackage

// File: rtl/lcd_req_fifo.sv
// Synchronous request FIFO; a push while full is accepted only alongside a pop.
module lcd_req_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Sequences LCD init commands, then drains queued CPU bytes to the 4-bit driver with settle gaps.
module lcd_write_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned INIT_WAIT  = 750000,
  parameter int unsigned CMD_WAIT   = 2000,
  parameter int unsigned CLEAR_WAIT = 82000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_write,
  input  logic [7:0]                    cpu_data,
  input  logic                          cpu_rs,
  output logic                          cpu_stall,
  output logic                          init_done,
  output logic                          drv_write,
  output logic [7:0]                    drv_data,
  output logic                          drv_rs,
  input  logic                          drv_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned MAX_WAIT =
    (INIT_WAIT > CLEAR_WAIT) ? ((INIT_WAIT > CMD_WAIT) ? INIT_WAIT : CMD_WAIT)
                             : ((CLEAR_WAIT > CMD_WAIT) ? CLEAR_WAIT : CMD_WAIT);
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_d;
  logic             init_done_d;
  logic             drv_write_d;
  logic [7:0]       drv_data_d;
  logic             drv_rs_d;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;
  lcd_req_t         req_in;
  lcd_req_t         head;

  assign req_in    = '{rs: cpu_rs, data: cpu_data};
  assign cpu_stall = fifo_full;

  lcd_req_fifo #(
    .WIDTH ($bits(lcd_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cpu_write),
    .pop   (pop_c),
    .wdata (req_in),
    .rdata (head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // drv_data/drv_rs hold the last issued byte, which selects the settle length.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = idx;
    init_done_d = init_done;
    drv_write_d = 1'b0;
    drv_data_d  = drv_data;
    drv_rs_d    = drv_rs;
    pop_c       = 1'b0;
    case (state)
      POWER_WAIT: begin
        if (cnt >= CNT_W'(INIT_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = INIT_ISSUE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      INIT_ISSUE: begin
        drv_write_d = 1'b1;
        drv_data_d  = init_rom(idx);
        drv_rs_d    = 1'b0;
        state_d     = ACK;
      end
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end
      ISSUE: begin
        drv_write_d = 1'b1;
        drv_data_d  = head.data;
        drv_rs_d    = head.rs;
        pop_c       = 1'b1;
        state_d     = ACK;
      end
      ACK: begin
        state_d = DRV_WAIT;
      end
      DRV_WAIT: begin
        if (!drv_busy) begin
          cnt_d   = is_long_cmd(drv_rs, drv_data) ? CNT_W'(CLEAR_WAIT) : CNT_W'(CMD_WAIT);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_d = '0;
          if (!init_done && (idx != IDX_W'(INIT_LEN - 1))) begin
            idx_d   = idx + IDX_W'(1);
            state_d = INIT_ISSUE;
          end else begin
            init_done_d = 1'b1;
            state_d     = fifo_empty ? IDLE : ISSUE;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = POWER_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= POWER_WAIT;
      cnt       <= '0;
      idx       <= '0;
      init_done <= 1'b0;
      drv_write <= 1'b0;
      drv_data  <= '0;
      drv_rs    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      idx       <= idx_d;
      init_done <= init_done_d;
      drv_write <= drv_write_d;
      drv_data  <= drv_data_d;
      drv_rs    <= drv_rs_d;
      overflow  <= overflow | fifo_drop;
    end
  end

endmodule

// File: doc/lcd_write_scheduler.md
Name: lcd_write_scheduler

Overview:
- Sequences all traffic to the shared 4-bit LCD driver (the block driving SF_D/LCD_E/LCD_RS/LCD_RW).
- Runs the mandatory power-on init command sequence first, then drains CPU byte requests from the LCD opcode through a small FIFO.
- Enforces per-command settle times and back-pressures the CPU instruction pointer with a stall signal when the FIFO is full.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
- INIT_WAIT, 750000, cycles after reset release before first init command (15 ms @ 50 MHz)
- CMD_WAIT, 2000, settle cycles after a normal command/data byte (40 us)
- CLEAR_WAIT, 82000, settle cycles after clear (0x01) or home (0x02) with RS=0 (1.64 ms)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- iCpuWrite  in  1  one-cycle byte write request from the LCD opcode
- iCpuData  in  8  byte to write
- iCpuRS  in  1  0 = command, 1 = data
- oCpuStall  out  1  FIFO full; CPU must hold its request
- oInitDone  out  1  high once all init commands have settled
- oDrvWrite  out  1  one-cycle start pulse to the LCD driver
- oDrvData  out  8  byte presented to the driver, valid while oDrvWrite is high
- oDrvRS  out  1  RS presented to the driver
- iDrvBusy  in  1  driver transferring nibbles; rises the cycle after oDrvWrite
- oOverflow  out  1  sticky; a request was dropped while the FIFO was full
- oLevel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - State = POWER_WAIT; FIFO emptied; all counters 0.
  - oDrvWrite=0, oDrvData=0, oDrvRS=0, oInitDone=0, oOverflow=0, oLevel=0, oCpuStall=0.
  - Reset asserted mid-transfer aborts immediately. After release, the full init sequence reruns and queued bytes are lost.
- All outputs are registered except oCpuStall and oLevel, which are decoded from the FIFO count.
- Init ROM, all RS=0, issued in order: 0x28, 0x06, 0x0C, 0x01.
- FSM states: POWER_WAIT, INIT_ISSUE, IDLE, ISSUE, ACK, DRV_WAIT, SETTLE.
  - POWER_WAIT: count INIT_WAIT cycles, then go to INIT_ISSUE.
  - INIT_ISSUE: drive oDrvWrite=1 for one cycle with ROM[idx], then go to ACK.
  - IDLE: if the FIFO is non-empty, go to ISSUE.
  - ISSUE: drive oDrvWrite=1 for one cycle with the FIFO head and pop it in the same cycle, then go to ACK.
  - ACK: ignore iDrvBusy for exactly one cycle, then go to DRV_WAIT.
  - DRV_WAIT: wait for iDrvBusy=0, then go to SETTLE.
  - SETTLE: load CLEAR_WAIT if the last byte had RS=0 and was 0x01 or 0x02, otherwise CMD_WAIT. Count it down to 1. Then:
    - if init is unfinished: idx++; go to INIT_ISSUE, or set oInitDone=1 after the 4th command;
    - if init is done: go to ISSUE if the FIFO is non-empty, else IDLE.
- oInitDone stays high until reset once set. CPU bytes are never issued before oInitDone=1.
- FIFO is 9 bits wide {RS, data}:
  - Push is accepted while oInitDone=0 (queued during init).
  - oCpuStall = (level == FIFO_DEPTH).
  - Push while full with no pop in the same cycle: request dropped, oOverflow set.
  - Push while full with a pop in the same cycle: request accepted, level unchanged, no overflow.
  - Push and pop on an empty FIFO are not simultaneous: pop only happens in ISSUE, which requires non-empty.
  - Read/write pointers wrap modulo FIFO_DEPTH; level saturates 0..FIFO_DEPTH.
- Latency, init done and FSM in IDLE with an empty FIFO:
  - push sampled at edge k;
  - state = ISSUE after edge k+1;
  - oDrvWrite high for the cycle following edge k+2.
- Minimum spacing between consecutive oDrvWrite pulses = 1 (ISSUE) + 1 (ACK) + busy duration + settle count + 1.
- Behaviour is undefined if iDrvBusy is already high at ACK exit when no write is pending. The driver contract forbids this; the bench asserts it.

Decomposition:
- Package lcd_sched_pkg holds:
  - state enum;
  - LCD command constants (FUNC_SET_4BIT=0x28, ENTRY_MODE=0x06, DISP_ON=0x0C, CLEAR=0x01, HOME=0x02);
  - init ROM length (4).
- Sub-module lcd_req_fifo: synchronous FIFO with parameters WIDTH=9 and DEPTH, providing push/pop/level/full/empty. Counters and FSM stay in the top.

Test Plan:
All scenarios use INIT_WAIT=20, CMD_WAIT=5, CLEAR_WAIT=12, and a driver model whose busy lasts 8 cycles.
- Reset release, no CPU traffic:
  - first oDrvWrite 20 cycles after release with data 0x28, RS=0;
  - then 0x06, 0x0C, 0x01 in order;
  - the wait after 0x01 uses 12 settle cycles;
  - oInitDone rises after the final settle.
- Init done, single push of 0x41 with RS=1: oDrvWrite high exactly 2 cycles after the push cycle, with oDrvData=0x41 and oDrvRS=1; oLevel returns to 0.
- Five pushes during init:
  - oCpuStall high after the 4th push;
  - 5th push dropped and oOverflow=1;
  - after init, exactly 4 bytes drain in FIFO order.
- FIFO full, push coincides with the ISSUE pop: push accepted, oOverflow stays 0, oLevel stays 4, order preserved.
- Command 0x01 with RS=0 from the CPU: 12 settle cycles before the next write. 0x01 with RS=1 uses 5.
- Reset asserted while iDrvBusy=1 mid-transfer: all outputs 0 asynchronously; after release the init sequence restarts and previously queued bytes are never issued.
